// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC; training from the ID stage commits on
// the clock edge. Two saturating statistics counters support perf debug.
module branch_target_buffer #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] predicted_pc,
    output logic                 pred_hit,
    input  logic                 btb_write,
    input  logic [1:0]           btb_src,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic [WORD_SIZE-1:0] jump_addr,
    input  logic                 flush,
    output logic [15:0]          stat_updates,
    output logic [15:0]          stat_flushes
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    typedef enum logic [1:0] {
        SRC_BR        = 2'd0,
        SRC_JR        = 2'd1,
        SRC_JUMP      = 2'd2,
        SRC_NOT_TAKEN = 2'd3
    } btb_src_e;

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic                 jmp_q    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_match;
    logic                  wr_en;
    logic [WORD_SIZE-1:0]  wr_target;
    logic [1:0]            wr_ctr;
    logic                  wr_jmp;
    btb_src_e              src;

    assign lk_idx = if_pc[INDEX_BITS-1:0];
    assign lk_tag = if_pc[WORD_SIZE-1:INDEX_BITS];
    assign wr_idx = id_pc[INDEX_BITS-1:0];
    assign wr_tag = id_pc[WORD_SIZE-1:INDEX_BITS];
    assign src    = btb_src_e'(btb_src);

    // Lookup: hit needs a valid matching entry that predicts taken; otherwise fall through to PC+1.
    always_comb begin
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)
                       && (jmp_q[lk_idx] || ctr_q[lk_idx][1]);
        predicted_pc = pred_hit ? target_q[lk_idx] : (if_pc + WORD_SIZE'(1));
    end

    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Training decode: compute the new entry contents for the indexed slot.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_en     = 1'b0;
        wr_target = target_q[wr_idx];
        wr_ctr    = ctr_q[wr_idx];
        wr_jmp    = jmp_q[wr_idx];
        if (btb_write) begin
            unique case (src)
                SRC_BR: begin
                    wr_en     = 1'b1;
                    wr_target = br_target;
                    wr_jmp    = 1'b0;
                    if (!wr_match)                 wr_ctr = 2'b10;
                    else if (ctr_q[wr_idx] != 2'b11) wr_ctr = ctr_q[wr_idx] + 2'd1;
                    else                           wr_ctr = 2'b11;
                end
                SRC_JR, SRC_JUMP: begin
                    wr_en     = 1'b1;
                    wr_target = (src == SRC_JR) ? jr_target : jump_addr;
                    wr_ctr    = 2'b11;
                    wr_jmp    = 1'b1;
                end
                SRC_NOT_TAKEN: begin
                    wr_en = wr_match;
                    if (ctr_q[wr_idx] != 2'b00) wr_ctr = ctr_q[wr_idx] - 2'd1;
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    // Valid bits: cleared by reset in one cycle, set on any committed training write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n)   valid_q         <= '0;
        else if (wr_en) valid_q[wr_idx] <= 1'b1;
    end

    // Entry payload: written on commit, never reset.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is not reset; a cleared valid bit masks it, so no reset fan-out is needed.
        if (reset_n && wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_ctr;
            jmp_q[wr_idx]    <= wr_jmp;
        end
    end

    // Statistics counters: saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_updates <= '0;
            stat_flushes <= '0;
        end else begin
            if (btb_write && (stat_updates != 16'hFFFF)) stat_updates <= stat_updates + 16'd1;
            if (flush && (stat_flushes != 16'hFFFF))     stat_flushes <= stat_flushes + 16'd1;
        end
    end

endmodule
